// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data memory controller for a simple CPU datapath.
// Each aligned access runs IDLE -> BUSY (LAT cycles) -> DONE. The CPU is
// stalled from the request cycle through the last BUSY cycle. Load data is
// registered and valid in DONE, and stores commit at the DONE clock edge.
// Optional feature macro: DMEM_MMIO_EN. When it is defined, byte address
// 0xFFFF_FFF0 maps to the io_out register instead of the data array.
module dmem_ctrl #(
  parameter int WORDS = 256,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign_err,
  output logic [31:0] io_out
);

  localparam int AW = $clog2(WORDS);
  localparam logic [2:0] LAT_C = 3'(LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [2:0]    cnt_q;
  logic [31:0]   adr_q;
  logic [31:0]   wdata_q;
  logic          store_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q [WORDS];

`ifdef DMEM_MMIO_EN
  logic [31:0]   io_q;
`endif

  logic          req_s;
  logic          aligned_s;
  logic          is_io_s;
  logic          commit_store_s;
  logic [AW-1:0] idx_s;

  // Request decode and the combinational handshake back to the CPU.
  always_comb begin
    req_s        = mem_read | mem_write;
    aligned_s    = (adr[1:0] == 2'b00);
    stall        = 1'b0;
    misalign_err = 1'b0;
    if (rst) begin
      stall        = 1'b0;
      misalign_err = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stall        = req_s & aligned_s;
          misalign_err = req_s & ~aligned_s;
        end
        BUSY: begin
          stall = 1'b1;
        end
        DONE: begin
          stall = 1'b0;
        end
        default: begin
          stall        = 1'b0;
          misalign_err = 1'b0;
        end
      endcase
    end
  end

  // Decode the latched address: word index, I/O hit, and store commit.
  // A store commits only in DONE and never in a cycle where reset is high.
  always_comb begin
    idx_s = adr_q[AW+1:2];
`ifdef DMEM_MMIO_EN
    is_io_s = (adr_q == 32'hFFFF_FFF0);
`else
    is_io_s = 1'b0;
`endif
    if ((state_q == DONE) && store_q && !rst && !is_io_s) begin
      commit_store_s = 1'b1;
    end else begin
      commit_store_s = 1'b0;
    end
  end

  // Access sequencer: latch the request, count wait cycles, and capture
  // load data on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      adr_q   <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      store_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
`ifdef DMEM_MMIO_EN
      io_q    <= 32'h0000_0000;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s && aligned_s) begin
            adr_q   <= adr;
            wdata_q <= wdata;
            // A simultaneous read and write is treated as a store.
            store_q <= mem_write;
            cnt_q   <= LAT_C;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= DONE;
            if (!store_q) begin
`ifdef DMEM_MMIO_EN
              if (is_io_s) begin
                rdata_q <= io_q;
              end else begin
                rdata_q <= mem_q[idx_s];
              end
`else
              rdata_q <= mem_q[idx_s];
`endif
            end
          end
        end
        DONE: begin
          // DONE always returns to IDLE, so a request that is still held
          // cannot start a second access.
          state_q <= IDLE;
`ifdef DMEM_MMIO_EN
          if (store_q && is_io_s) begin
            io_q <= wdata_q;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  // Data array write port. The array has no reset, so its contents
  // survive a reset.
  always_ff @(posedge clk) begin
    if (commit_store_s) begin
      mem_q[idx_s] <= wdata_q;
    end
  end

  assign rdata = rdata_q;

`ifdef DMEM_MMIO_EN
  assign io_out = io_q;
`else
  assign io_out = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed, table-driven bench for dmem_ctrl (WORDS=256, LAT=2).
// The expectations track whether DMEM_MMIO_EN is defined.
module tb_dmem_ctrl;

  localparam int WORDS = 256;
  localparam int LAT   = 2;

`ifdef DMEM_MMIO_EN
  localparam logic [31:0] IO_AFTER = 32'h0000_0055;
  localparam logic [31:0] RD_3F0   = 32'h7777_7777;
`else
  localparam logic [31:0] IO_AFTER = 32'h0000_0000;
  localparam logic [31:0] RD_3F0   = 32'h0000_0055;
`endif

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign_err;
  logic [31:0] io_out;

  int tests;
  int fails;
  longint t_start;
  longint t_done;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [31:0] exp_io;
  } vec_t;

  vec_t v [14];

  dmem_ctrl #(.WORDS(WORDS), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .adr          (adr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misalign_err (misalign_err),
    .io_out       (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One CPU access, starting at the next falling edge (an IDLE cycle).
  // It returns in the DONE cycle with the request still held, or in the
  // same IDLE cycle for a misaligned request.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input string nm);
    int n;
    @(negedge clk);
    mem_read = rd; mem_write = wr; adr = a; wdata = d;
    #1;
    t_start = $time;
    if (a[1:0] != 2'b00) begin
      chk({nm, " misalign_err"}, 32'(misalign_err), 32'h1);
      chk({nm, " stall"}, 32'(stall), 32'h0);
      chk({nm, " rdata"}, rdata, exp_rd);
    end else begin
      chk({nm, " misalign_err"}, 32'(misalign_err), 32'h0);
      n = 0;
      while (stall && n < 20) begin
        n++;
        @(negedge clk);
        #1;
      end
      t_done = $time;
      chk({nm, " stall_cycles"}, 32'(n), 32'(LAT + 1));
      chk({nm, " rdata"}, rdata, exp_rd);
    end
  endtask

  // Drop the request and confirm the controller sits in IDLE.
  task automatic idle_chk(input string nm);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    chk({nm, " idle stall"}, 32'(stall), 32'h0);
    chk({nm, " idle misalign_err"}, 32'(misalign_err), 32'h0);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    adr = 32'h0; wdata = 32'h0;

    v[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0};
    v[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
    v[2]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0};
    v[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
    v[4]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
    v[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
    v[6]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h0};
    v[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0};
    v[8]  = '{1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 32'hA5A5_A5A5, 32'h0};
    v[9]  = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'hCAFE_F00D, 32'h0};
    v[10] = '{1'b0, 1'b1, 32'h0000_03F0, 32'h7777_7777, 32'hCAFE_F00D, 32'h0};
    v[11] = '{1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0055, 32'hCAFE_F00D, IO_AFTER};
    v[12] = '{1'b1, 1'b0, 32'h0000_03F0, 32'h0000_0000, RD_3F0,        IO_AFTER};
    v[13] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0055, IO_AFTER};

    // While reset is held, requests are ignored and the outputs are cleared.
    mem_read = 1'b1; adr = 32'h0000_0010;
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset io_out", io_out, 32'h0);
    adr = 32'h0000_0013;
    #1;
    chk("reset misalign_err", 32'(misalign_err), 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0; adr = 32'h0;

    for (int i = 0; i < 14; i++) begin
      access(v[i].rd, v[i].wr, v[i].a, v[i].d, v[i].exp_rd, $sformatf("vec%0d", i));
      idle_chk($sformatf("vec%0d", i));
      chk($sformatf("vec%0d io_out", i), io_out, v[i].exp_io);
    end

    // Back-to-back store then load to 0x20 without an idle gap.
    access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0055, "b2b store");
    begin
      longint t0;
      t0 = t_start;
      access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, "b2b load");
      chk("b2b total cycles", 32'((t_done - t0) / 10 + 1), 32'd8);
    end
    idle_chk("b2b");

    // Reset in the second BUSY cycle of a store of 0x1 to 0x8 aborts it.
    @(negedge clk);
    mem_write = 1'b1; adr = 32'h0000_0008; wdata = 32'h0000_0001;
    #1;
    chk("abort req stall", 32'(stall), 32'h1);
    @(negedge clk); #1;
    chk("abort busy1 stall", 32'(stall), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort rst stall", 32'(stall), 32'h0);
    chk("abort rst misalign_err", 32'(misalign_err), 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0;
    #1;
    chk("abort idle stall", 32'(stall), 32'h0);
    chk("abort rdata cleared", rdata, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h1111_1111, "abort reload");
    idle_chk("abort reload");

    // Inputs that change during BUSY must not affect the latched store.
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0; adr = 32'h0000_0040; wdata = 32'h0BAD_F00D;
    #1;
    chk("latch req stall", 32'(stall), 32'h1);
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1; adr = 32'h0000_0044; wdata = 32'hFFFF_FFFF;
    #1;
    chk("latch busy1 stall", 32'(stall), 32'h1);
    @(negedge clk); #1;
    chk("latch busy2 stall", 32'(stall), 32'h1);
    @(negedge clk); #1;
    chk("latch done stall", 32'(stall), 32'h0);
    chk("latch done rdata", rdata, 32'h1111_1111);
    idle_chk("latch");
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, "latch reload");
    idle_chk("latch reload");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
